// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the scalar/vector memory arbiter.
// Arbitration mode is selected in rr_arbiter2 by MEM_ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

    localparam int LANES  = 16;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef logic [LANES-1:0][DATA_W-1:0] vec_t;

    // A scalar write travels on the top lane; every other lane is zero.
    function automatic vec_t scalar_lane(input logic [DATA_W-1:0] data);
        vec_t v;
        v            = '0;
        v[LANES-1]   = data;
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way winner select: bit 1 = vector, bit 0 = scalar.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin on ties; otherwise vector has fixed priority.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On a tie the requester not granted last wins (last=1 means vector won last).
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end
`else
    logic unused_last_s;
    assign unused_last_s = last;

    // Fixed priority: vector always wins a tie.
    always_comb begin
        gnt = 2'b00;
        if (req[1]) begin
            gnt = 2'b10;
        end else begin
            gnt = req;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a scalar and a vector requester onto one 16-bank memory port.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie breaking (default: vector priority).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_req,
    input  logic              s_wr,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_wdata,
    output logic              s_gnt,
    output logic              s_rvalid,
    output logic [DATA_W-1:0] s_rdata,
    input  logic              v_req,
    input  logic              v_wr,
    input  logic [ADDR_W-1:0] v_addr,
    input  vec_t              v_wdata,
    output logic              v_gnt,
    output logic              v_rvalid,
    output vec_t              v_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output vec_t              mem_data,
    output logic              mem_wren,
    output logic              mem_vec_scalar,
    input  vec_t              mem_q
);

    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    state_t              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    vec_t                mem_data_q, mem_data_d;
    logic                mem_wren_q, mem_wren_d;
    logic                mem_vec_q, mem_vec_d;
    logic                s_rvalid_q, s_rvalid_d;
    logic                v_rvalid_q, v_rvalid_d;
    logic [DATA_W-1:0]   s_rdata_q, s_rdata_d;
    vec_t                v_rdata_q, v_rdata_d;
    logic [1:0]          arb_gnt_s;
    logic                grant_en_s;
    logic                last_s;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
    assign last_s = last_q;
`else
    assign last_s = 1'b0;
`endif

    rr_arbiter2 u_arb (
        .req  ({v_req, s_req}),
        .last (last_s),
        .gnt  (arb_gnt_s)
    );

    // Grants are combinational so the requester sees acceptance in its request cycle.
    assign grant_en_s = (state_q == IDLE) && !rst;
    assign s_gnt      = grant_en_s & arb_gnt_s[0];
    assign v_gnt      = grant_en_s & arb_gnt_s[1];

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mem_address_d = '0;
        mem_data_d    = '0;
        mem_wren_d    = 1'b0;
        mem_vec_d     = 1'b0;
        s_rvalid_d    = 1'b0;
        v_rvalid_d    = 1'b0;
        s_rdata_d     = s_rdata_q;
        v_rdata_d     = v_rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d        = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (s_gnt || v_gnt) begin
                    mem_vec_d     = v_gnt;
                    mem_address_d = v_gnt ? v_addr : s_addr;
                    cnt_d         = CNT_INIT;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_d        = v_gnt;
`endif
                    if (v_gnt ? v_wr : s_wr) begin
                        state_d    = WRITE;
                        mem_wren_d = 1'b1;
                        mem_data_d = v_gnt ? v_wdata : scalar_lane(s_wdata);
                    end else begin
                        state_d    = READ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            READ: begin
                // mem_q is captured on the last READ edge, while the address is still driven.
                if (cnt_q == 2'd0) begin
                    state_d = RESP;
                    if (mem_vec_q) begin
                        v_rvalid_d = 1'b1;
                        v_rdata_d  = mem_q;
                    end else begin
                        s_rvalid_d = 1'b1;
                        s_rdata_d  = mem_q[0];
                    end
                end else begin
                    cnt_d         = cnt_q - 2'd1;
                    mem_address_d = mem_address_q;
                    mem_vec_d     = mem_vec_q;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs, synchronously cleared by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 2'd0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            mem_wren_q    <= 1'b0;
            mem_vec_q     <= 1'b0;
            s_rvalid_q    <= 1'b0;
            v_rvalid_q    <= 1'b0;
            s_rdata_q     <= '0;
            v_rdata_q     <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            mem_wren_q    <= mem_wren_d;
            mem_vec_q     <= mem_vec_d;
            s_rvalid_q    <= s_rvalid_d;
            v_rvalid_q    <= v_rvalid_d;
            s_rdata_q     <= s_rdata_d;
            v_rdata_q     <= v_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q        <= last_d;
`endif
        end
    end

    assign mem_address    = mem_address_q;
    assign mem_data       = mem_data_q;
    assign mem_wren       = mem_wren_q;
    assign mem_vec_scalar = mem_vec_q;
    assign s_rvalid       = s_rvalid_q;
    assign v_rvalid       = v_rvalid_q;
    assign s_rdata        = s_rdata_q;
    assign v_rdata        = v_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (RD_LAT=2); tie-break expectation
// follows MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_req, s_wr, s_gnt, s_rvalid;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata, s_rdata;
    logic              v_req, v_wr, v_gnt, v_rvalid;
    logic [ADDR_W-1:0] v_addr;
    vec_t              v_wdata, v_rdata;
    logic [ADDR_W-1:0] mem_address;
    vec_t              mem_data, mem_q;
    logic              mem_wren, mem_vec_scalar;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.RD_LAT(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .s_req          (s_req),
        .s_wr           (s_wr),
        .s_addr         (s_addr),
        .s_wdata        (s_wdata),
        .s_gnt          (s_gnt),
        .s_rvalid       (s_rvalid),
        .s_rdata        (s_rdata),
        .v_req          (v_req),
        .v_wr           (v_wr),
        .v_addr         (v_addr),
        .v_wdata        (v_wdata),
        .v_gnt          (v_gnt),
        .v_rvalid       (v_rvalid),
        .v_rdata        (v_rdata),
        .mem_address    (mem_address),
        .mem_data       (mem_data),
        .mem_wren       (mem_wren),
        .mem_vec_scalar (mem_vec_scalar),
        .mem_q          (mem_q)
    );

    // Bank model: lane i returns address + i.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            mem_q[i] = 32'(mem_address) + 32'(i);
        end
    end

    function automatic vec_t ramp(input logic [31:0] base);
        vec_t r;
        for (int i = 0; i < LANES; i++) begin
            r[i] = base + 32'(i);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t       exp_v;
        logic [3:0] pat;
        logic [3:0] exp_pat;
        logic       seen_rv;
        int         waited;

        rst = 1'b1; s_req = 1'b0; s_wr = 1'b0; s_addr = '0; s_wdata = '0;
        v_req = 1'b0; v_wr = 1'b0; v_addr = '0; v_wdata = '0;
        tick(); tick();
        check("rst_wren", 512'(mem_wren), 512'(1'b0));
        check("rst_addr", 512'(mem_address), 512'(13'h0));
        check("rst_rvalid", 512'({s_rvalid, v_rvalid}), 512'(2'b00));
        s_req = 1'b1; v_req = 1'b1; #1;
        check("rst_no_gnt", 512'({s_gnt, v_gnt}), 512'(2'b00));
        s_req = 1'b0; v_req = 1'b0;
        tick(); rst = 1'b0; tick();

        // Scalar write
        s_req = 1'b1; s_wr = 1'b1; s_addr = 13'h0010; s_wdata = 32'hBEEF; #1;
        check("sw_gnt", 512'({s_gnt, v_gnt}), 512'(2'b10));
        tick(); s_req = 1'b0; #1;
        check("sw_wren", 512'(mem_wren), 512'(1'b1));
        check("sw_vs", 512'(mem_vec_scalar), 512'(1'b0));
        check("sw_addr", 512'(mem_address), 512'(13'h0010));
        exp_v = '0; exp_v[15] = 32'hBEEF;
        check("sw_data", 512'(mem_data), 512'(exp_v));
        tick();
        check("sw_idle_wren", 512'(mem_wren), 512'(1'b0));
        check("sw_idle_data", 512'(mem_data), 512'(1'b0));

        // Vector read, rvalid 3 cycles after grant
        v_req = 1'b1; v_wr = 1'b0; v_addr = 13'h0100; #1;
        check("vr_gnt", 512'({s_gnt, v_gnt}), 512'(2'b01));
        tick(); v_req = 1'b0; #1;
        check("vr_addr", 512'(mem_address), 512'(13'h0100));
        check("vr_vs", 512'(mem_vec_scalar), 512'(1'b1));
        check("vr_wren", 512'(mem_wren), 512'(1'b0));
        check("vr_rv1", 512'(v_rvalid), 512'(1'b0));
        tick();
        check("vr_rv2", 512'(v_rvalid), 512'(1'b0));
        tick();
        check("vr_rv3", 512'(v_rvalid), 512'(1'b1));
        check("vr_data", 512'(v_rdata), 512'(ramp(32'h100)));
        tick();
        check("vr_rv_drop", 512'(v_rvalid), 512'(1'b0));
        check("vr_hold", 512'(v_rdata), 512'(ramp(32'h100)));

        // Vector write at top of address space
        v_req = 1'b1; v_wr = 1'b1; v_addr = 13'h1FF8; v_wdata = ramp(32'hA000); #1;
        check("vw_gnt", 512'({s_gnt, v_gnt}), 512'(2'b01));
        tick(); v_req = 1'b0; #1;
        check("vw_addr", 512'(mem_address), 512'(13'h1FF8));
        check("vw_wren", 512'(mem_wren), 512'(1'b1));
        check("vw_vs", 512'(mem_vec_scalar), 512'(1'b1));
        check("vw_data", 512'(mem_data), 512'(ramp(32'hA000)));
        tick();
        check("vw_wren_drop", 512'(mem_wren), 512'(1'b0));
        check("vw_no_rvalid", 512'(v_rvalid), 512'(1'b0));

        // Scalar request waits while a vector read is in flight
        v_req = 1'b1; v_wr = 1'b0; v_addr = 13'h0020; #1;
        check("vr2_gnt", 512'({s_gnt, v_gnt}), 512'(2'b01));
        tick(); v_req = 1'b0; s_req = 1'b1; s_wr = 1'b0; s_addr = 13'h0055; #1;
        check("busy_gnt1", 512'({s_gnt, v_gnt}), 512'(2'b00));
        tick();
        check("busy_gnt2", 512'({s_gnt, v_gnt}), 512'(2'b00));
        tick();
        check("vr2_rv", 512'(v_rvalid), 512'(1'b1));
        check("busy_gnt3", 512'({s_gnt, v_gnt}), 512'(2'b00));
        tick();
        check("s_gnt_after", 512'({s_gnt, v_gnt}), 512'(2'b10));
        tick(); s_req = 1'b0;
        tick(); tick();
        check("sr_rv", 512'(s_rvalid), 512'(1'b1));
        check("sr_data", 512'(s_rdata), 512'(32'h55));
        check("sr_v_quiet", 512'(v_rvalid), 512'(1'b0));
        check("v_hold2", 512'(v_rdata), 512'(ramp(32'h20)));
        tick();

        // Reset in the middle of a scalar read
        s_req = 1'b1; s_wr = 1'b0; s_addr = 13'h0077; #1;
        check("sr3_gnt", 512'({s_gnt, v_gnt}), 512'(2'b10));
        tick(); s_req = 1'b0; rst = 1'b1;
        tick(); rst = 1'b0;
        check("rst_rd_addr", 512'(mem_address), 512'(13'h0));
        check("rst_rd_rdata", 512'(s_rdata), 512'(32'h0));
        seen_rv = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (s_rvalid) seen_rv = 1'b1;
            tick();
        end
        check("no_rvalid_after_rst", 512'(seen_rv), 512'(1'b0));
        s_req = 1'b1; s_wr = 1'b1; s_addr = 13'h0033; s_wdata = 32'h1234; #1;
        check("post_rst_gnt", 512'({s_gnt, v_gnt}), 512'(2'b10));
        tick(); s_req = 1'b0; #1;
        check("post_rst_wren", 512'(mem_wren), 512'(1'b1));
        exp_v = '0; exp_v[15] = 32'h1234;
        check("post_rst_data", 512'(mem_data), 512'(exp_v));
        tick();

        // Both requesters held for four writes
        s_req = 1'b1; s_wr = 1'b1; s_addr = 13'h0001; s_wdata = 32'h5;
        v_req = 1'b1; v_wr = 1'b1; v_addr = 13'h0002; v_wdata = ramp(32'h0);
        pat = 4'b0000;
        for (int op = 0; op < 4; op++) begin
            waited = 0;
            #1;
            while (!(s_gnt || v_gnt) && waited < 8) begin
                tick(); #1;
                waited++;
            end
            check("tie_grant", 512'(s_gnt | v_gnt), 512'(1'b1));
            check("tie_onehot", 512'(s_gnt & v_gnt), 512'(1'b0));
            pat = {pat[2:0], v_gnt};
            tick();
        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_pat = 4'b1010;
`else
        exp_pat = 4'b1111;
`endif
        check("tie_pattern", 512'(pat), 512'(exp_pat));
        s_req = 1'b0; v_req = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
